// File: rtl/theta_slice_sequencer.sv
// Slice-serial theta front end: buffers 64 slices of a Keccak state, then
// replays them as (slice[z-1], slice[z]) pairs for the column-parity stage.
module theta_slice_sequencer #(
  parameter int SLICE_W    = 25,
  parameter int NUM_SLICES = 64,
  parameter int IDX_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_prev,
  output logic [SLICE_W-1:0] out_curr,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   prev_idx;
  logic [SLICE_W-1:0] slice_q [NUM_SLICES];
  logic               emit;
  logic               wrap;
  logic               in_fire;
  logic               out_fire;

  always_comb begin
    emit      = (state_q == EMIT);
    // IDX_W-bit wraparound gives slice 63 as predecessor of slice 0
    prev_idx  = cnt_q - IDX_W'(1);
    wrap      = (cnt_q == IDX_W'(NUM_SLICES - 1));
    in_ready  = !emit && !rst;
    out_valid = emit;
    busy      = emit;
    out_idx   = emit ? cnt_q : '0;
    out_last  = emit && wrap;
    out_curr  = emit ? slice_q[cnt_q] : '0;
    out_prev  = emit ? slice_q[prev_idx] : '0;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (in_fire || out_fire) cnt_d = cnt_q + IDX_W'(1);
    if (in_fire && wrap) state_d = EMIT;
    if (out_fire && wrap) state_d = LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_SLICES; i++) slice_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_fire) slice_q[cnt_q] <= in_slice;
    end
  end

endmodule
